// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC and IR, runs the
//               req/ack handshake to instruction memory and drives the
//               phase-generator HOLD. Optional watchdog: FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int PC_WIDTH    = 7,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                i_ir_en,
  input  logic                i_pc_en,
  input  logic                i_pc_load,
  input  logic                i_mem_ack,
  input  logic [11:0]         i_mem_data,
  output logic                o_mem_req,
  output logic [PC_WIDTH-1:0] o_mem_addr,
  output logic [3:0]          o_opcode,
  output logic                o_i_flag,
  output logic [6:0]          o_addr,
  output logic                o_hold,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] c_RESET_PC = PC_WIDTH'(RESET_PC);

  state_t              r_state;
  state_t              w_next_state;
  logic [11:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_mem_addr;
  logic                r_pc_en_d;
  logic                w_mem_req;
  logic                w_hold;
  logic                w_timeout;
  logic                w_pc_update;
  logic [PC_WIDTH-1:0] w_addr_ext;

  assign w_pc_update = i_pc_en & ~r_pc_en_d;
  assign w_addr_ext  = PC_WIDTH'(r_ir[6:0]);

`ifdef FETCH_TIMEOUT_EN
  localparam int                c_TO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MEM_TIMEOUT - 1);

  logic [c_TO_W-1:0] r_to_cnt;

  // Counter holds the number of REQ cycles already spent without an ACK.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_to_cnt <= '0;
    end else if (r_state == IDLE && i_ir_en) begin
      r_to_cnt <= '0;
    end else if (r_state == REQ && !i_mem_ack && !w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_to_cnt == c_TO_LAST);
  assign o_fault   = (r_state == FAULT);
`else
  localparam int c_unused_timeout = MEM_TIMEOUT;

  assign w_timeout = 1'b0;
  assign o_fault   = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_hold       = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold = i_ir_en;
        if (i_ir_en) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_mem_req = 1'b1;
        w_hold    = i_ir_en;
        // An ACK on the last permitted cycle still wins over the timeout.
        if (i_mem_ack) begin
          w_next_state = DONE;
        end else if (w_timeout) begin
          w_next_state = FAULT;
        end
      end
      DONE: begin
        if (!i_ir_en) begin
          w_next_state = IDLE;
        end
      end
      FAULT: begin
        w_hold = 1'b1;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_ir       <= '0;
      r_pc       <= c_RESET_PC;
      r_mem_addr <= c_RESET_PC;
      r_pc_en_d  <= 1'b0;
    end else begin
      r_pc_en_d <= i_pc_en;
      if (r_state == IDLE && i_ir_en) begin
        r_mem_addr <= r_pc;
      end
      if (r_state == REQ && i_mem_ack) begin
        r_ir <= i_mem_data;
      end
      // PC update is decoupled from the fetch FSM; MEM_ADDR keeps its copy.
      if (w_pc_update) begin
        if (i_pc_load) begin
          r_pc <= w_addr_ext;
        end else begin
          r_pc <= r_pc + 1'b1;
        end
      end
    end
  end

  assign o_mem_req  = w_mem_req;
  assign o_hold     = w_hold;
  assign o_mem_addr = r_mem_addr;
  assign o_opcode   = r_ir[11:8];
  assign o_i_flag   = r_ir[7];
  assign o_addr     = r_ir[6:0];
  assign o_pc       = r_pc;

endmodule

`default_nettype wire
